// File: rtl/tl_rx_vc_data_wr_ctrl.sv
// rtl/tl_rx_vc_data_wr_ctrl.sv - RX VC data buffer write-side controller with free-space check and rollback
module tl_rx_vc_data_wr_ctrl #(
    parameter int DATA_FIFO_DEPTH = 256,
    parameter int DATA_PTR_SIZE   = $clog2(DATA_FIFO_DEPTH) + 1,
    parameter int BUFFER_WIDTH    = 256
) (
    input  logic                     i_clk,
    input  logic                     i_n_rst,
    input  logic                     i_tlp_valid,
    output logic                     o_ready,
    input  logic                     i_tlp_sop,
    input  logic                     i_tlp_eop,
    input  logic                     i_tlp_digest,
    input  logic                     i_tlp_discard,
    input  logic [BUFFER_WIDTH-1:0]  i_tlp_data,
    input  logic [DATA_PTR_SIZE-1:0] i_w_data_ptr,
    input  logic [DATA_PTR_SIZE-1:0] i_r_data_ptr,
    output logic                     o_w_data_en,
    output logic [BUFFER_WIDTH-1:0]  o_w_tlp_data,
    output logic                     o_w_data_cntr_ld,
    output logic                     o_w_data_ptr_ld,
    output logic                     o_digest_cycle_flag,
    output logic                     o_commit,
    output logic [DATA_PTR_SIZE-1:0] o_commit_beats,
    input  logic                     i_err_clr,
    output logic                     o_overflow_err,
    output logic                     o_protocol_err
);

    localparam logic [DATA_PTR_SIZE-1:0] DEPTH_P = DATA_PTR_SIZE'(DATA_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DROP, REALIGN} state_t;

    state_t                   state_q, state_d;
    logic [DATA_PTR_SIZE-1:0] n_q, n_d, n_inc;
    logic [DATA_PTR_SIZE-1:0] used, free;
    logic [DATA_PTR_SIZE-1:0] commit_beats_q, commit_beats_d;
    logic                     commit_q, commit_d;
    logic                     ovf_q, prot_q, ovf_set, prot_set;
    logic                     acc, space_ok, do_eop, overflow;
    logic                     wen, cntr_ld, ptr_ld, dig_flag;

    // Used space wraps modulo the pointer width; free is at most DEPTH, so n never exceeds it
    assign used     = i_w_data_ptr - i_r_data_ptr;
    assign free     = DEPTH_P - used;
    assign space_ok = (n_q < free);
    assign n_inc    = (n_q == DEPTH_P) ? n_q : n_q + DATA_PTR_SIZE'(1);

    assign o_ready  = i_n_rst && (state_q != REALIGN);
    assign acc      = i_tlp_valid && o_ready;

    // Next state, beat counter and zero-latency buffer controls
    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        wen            = 1'b0;
        cntr_ld        = 1'b0;
        ptr_ld         = 1'b0;
        dig_flag       = 1'b0;
        commit_d       = 1'b0;
        commit_beats_d = '0;
        ovf_set        = 1'b0;
        prot_set       = 1'b0;
        do_eop         = 1'b0;
        overflow       = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc && i_tlp_sop) begin
                    if (i_tlp_eop) begin
                        do_eop = 1'b1;
                    end else if (space_ok) begin
                        wen     = 1'b1;
                        n_d     = DATA_PTR_SIZE'(1);
                        state_d = RECV;
                    end else begin
                        overflow = 1'b1;
                    end
                end
            end
            RECV: begin
                if (acc) begin
                    if (i_tlp_sop) begin
                        // A new sop inside a TLP poisons both TLPs
                        cntr_ld  = 1'b1;
                        prot_set = 1'b1;
                        state_d  = i_tlp_eop ? IDLE : DROP;
                        n_d      = i_tlp_eop ? '0 : n_q;
                    end else if (i_tlp_eop) begin
                        do_eop = 1'b1;
                    end else if (space_ok) begin
                        wen = 1'b1;
                        n_d = n_inc;
                    end else begin
                        overflow = 1'b1;
                    end
                end
            end
            DROP: begin
                if (acc && i_tlp_eop) begin
                    state_d = IDLE;
                    n_d     = '0;
                end
            end
            REALIGN: begin
                // Write counter is one beat past the commit after a digest beat
                cntr_ld = 1'b1;
                state_d = IDLE;
                n_d     = '0;
            end
            default: begin
                state_d = IDLE;
                n_d     = '0;
            end
        endcase

        if (do_eop) begin
            if (i_tlp_discard) begin
                cntr_ld = 1'b1;
                state_d = IDLE;
                n_d     = '0;
            end else if (space_ok) begin
                wen            = 1'b1;
                ptr_ld         = 1'b1;
                dig_flag       = i_tlp_digest;
                commit_d       = 1'b1;
                commit_beats_d = i_tlp_digest ? n_q : n_inc;
                state_d        = i_tlp_digest ? REALIGN : IDLE;
                n_d            = '0;
            end else begin
                overflow = 1'b1;
            end
        end

        if (overflow) begin
            cntr_ld = 1'b1;
            ovf_set = 1'b1;
            state_d = i_tlp_eop ? IDLE : DROP;
            n_d     = i_tlp_eop ? '0 : n_q;
        end
    end

    // State, counter, commit report and sticky errors
    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            state_q        <= IDLE;
            n_q            <= '0;
            commit_q       <= 1'b0;
            commit_beats_q <= '0;
            ovf_q          <= 1'b0;
            prot_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            commit_q       <= commit_d;
            commit_beats_q <= commit_beats_d;
            ovf_q          <= ovf_set  | (ovf_q  & ~i_err_clr);
            prot_q         <= prot_set | (prot_q & ~i_err_clr);
        end
    end

    // Reset suppresses all buffer controls so no rollback reaches the buffer
    assign o_w_data_en         = wen      & i_n_rst;
    assign o_w_data_cntr_ld    = cntr_ld  & i_n_rst;
    assign o_w_data_ptr_ld     = ptr_ld   & i_n_rst;
    assign o_digest_cycle_flag = dig_flag & i_n_rst;
    assign o_w_tlp_data        = i_tlp_data;
    assign o_commit            = commit_q;
    assign o_commit_beats      = commit_beats_q;
    assign o_overflow_err      = ovf_q;
    assign o_protocol_err      = prot_q;

endmodule

// File: tb/tb_tl_rx_vc_data_wr_ctrl.sv
// tb/tb_tl_rx_vc_data_wr_ctrl.sv - scoreboard bench for tl_rx_vc_data_wr_ctrl
module tb_tl_rx_vc_data_wr_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid, sop, eop, dig, dsc, err_clr;
    logic [255:0] data;
    logic [8:0]   w_ptr, r_ptr;
    logic         ready, wen, cl, pl, fl, cm, ovf, prot;
    logic [255:0] w_data;
    logic [8:0]   beats;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         wen;
        logic         cl;
        logic         pl;
        logic         fl;
        logic         cm;
        logic [8:0]   beats;
        logic [255:0] data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    tl_rx_vc_data_wr_ctrl dut (
        .i_clk               (clk),
        .i_n_rst             (rst_n),
        .i_tlp_valid         (valid),
        .o_ready             (ready),
        .i_tlp_sop           (sop),
        .i_tlp_eop           (eop),
        .i_tlp_digest        (dig),
        .i_tlp_discard       (dsc),
        .i_tlp_data          (data),
        .i_w_data_ptr        (w_ptr),
        .i_r_data_ptr        (r_ptr),
        .o_w_data_en         (wen),
        .o_w_tlp_data        (w_data),
        .o_w_data_cntr_ld    (cl),
        .o_w_data_ptr_ld     (pl),
        .o_digest_cycle_flag (fl),
        .o_commit            (cm),
        .o_commit_beats      (beats),
        .i_err_clr           (err_clr),
        .o_overflow_err      (ovf),
        .o_protocol_err      (prot)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Monitor: any active control output consumes one expected record
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (wen | cl | pl | cm)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got wen=%0b cl=%0b pl=%0b fl=%0b commit=%0b", wen, cl, pl, fl, cm);
            end else begin
                mon_e = q.pop_front();
                if ({wen, cl, pl, fl, cm} !== {mon_e.wen, mon_e.cl, mon_e.pl, mon_e.fl, mon_e.cm} ||
                    (mon_e.cm && beats !== mon_e.beats) ||
                    (mon_e.wen && w_data !== mon_e.data)) begin
                    errors++;
                    $display("FAIL ctrl got wen=%0b cl=%0b pl=%0b fl=%0b commit=%0b beats=%0d data=%h exp wen=%0b cl=%0b pl=%0b fl=%0b commit=%0b beats=%0d data=%h",
                             wen, cl, pl, fl, cm, beats, w_data,
                             mon_e.wen, mon_e.cl, mon_e.pl, mon_e.fl, mon_e.cm, mon_e.beats, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    // One accepted beat; pushes the expected controls for this cycle if any
    task automatic beat(input logic s, input logic e, input logic dg, input logic dc,
                        input logic [31:0] k,
                        input logic ew, input logic ecl, input logic epl, input logic efl);
        logic [255:0] d;
        d = {8{k}};
        if (ew | ecl | epl)
            q.push_back('{wen: ew, cl: ecl, pl: epl, fl: efl, cm: 1'b0, beats: 9'd0, data: d});
        valid = 1'b1; sop = s; eop = e; dig = dg; dsc = dc; data = d;
        @(posedge clk); #1;
        valid = 1'b0; sop = 1'b0; eop = 1'b0; dig = 1'b0; dsc = 1'b0;
    endtask

    // Idle cycle with optional expected rollback/commit and expected ready
    task automatic gap(input logic ecl, input logic ecm, input logic [8:0] eb, input logic exp_rdy);
        if (ecl | ecm)
            q.push_back('{wen: 1'b0, cl: ecl, pl: 1'b0, fl: 1'b0, cm: ecm, beats: eb, data: '0});
        valid = 1'b0;
        @(negedge clk);
        chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
        @(posedge clk); #1;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        chk("prot_cleared", {31'd0, prot}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0; dig = 1'b0; dsc = 1'b0;
        err_clr = 1'b0; data = '0; w_ptr = 9'd0; r_ptr = 9'd0;

        // Reset: outputs quiet even with a sop beat offered
        repeat (2) @(posedge clk);
        #1; valid = 1'b1; sop = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_ctrl", {27'd0, wen, cl, pl, fl, cm}, 32'd0);
        chk("rst_beats", {23'd0, beats}, 32'd0);
        chk("rst_errs", {30'd0, ovf, prot}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; valid = 1'b0; sop = 1'b0;

        // 4-beat TLP, empty buffer
        beat(1, 0, 0, 0, 32'h1001, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h1002, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h1003, 1, 0, 0, 0);
        beat(0, 1, 0, 0, 32'h1004, 1, 0, 1, 0);
        gap(0, 1, 9'd4, 1);

        // 3-beat TLP with digest: commit 2, then realign
        beat(1, 0, 0, 0, 32'h2001, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h2002, 1, 0, 0, 0);
        beat(0, 1, 1, 0, 32'h2003, 1, 0, 1, 1);
        gap(1, 1, 9'd2, 0);
        gap(0, 0, 9'd0, 1);

        // 5-beat TLP discarded at eop
        beat(1, 0, 0, 0, 32'h3001, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h3002, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h3003, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h3004, 1, 0, 0, 0);
        beat(0, 1, 0, 1, 32'h3005, 0, 1, 0, 0);
        gap(0, 0, 9'd0, 1);
        chk("discard_no_err", {30'd0, ovf, prot}, 32'd0);

        // Free = 2: overflow on beat 3, beat 4 dropped
        w_ptr = 9'd254; r_ptr = 9'd0;
        beat(1, 0, 0, 0, 32'h4001, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h4002, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h4003, 0, 1, 0, 0);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        beat(0, 1, 0, 0, 32'h4004, 0, 0, 0, 0);
        gap(0, 0, 9'd0, 1);
        clear_errs();

        // Full buffer: single-beat TLP overflows and returns to IDLE
        w_ptr = 9'h100; r_ptr = 9'h000;
        beat(1, 1, 0, 0, 32'h4101, 0, 1, 0, 0);
        chk("ovf_full", {31'd0, ovf}, 32'd1);
        clear_errs();

        // Wrapped pointers, used 254, free 2
        w_ptr = 9'h1FE; r_ptr = 9'h100;
        beat(1, 0, 0, 0, 32'h5001, 1, 0, 0, 0);
        beat(0, 1, 0, 0, 32'h5002, 1, 0, 1, 0);
        gap(0, 1, 9'd2, 1);

        // sop inside a TLP
        w_ptr = 9'd0; r_ptr = 9'd0;
        beat(1, 0, 0, 0, 32'h6001, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h6002, 1, 0, 0, 0);
        beat(1, 0, 0, 0, 32'h6003, 0, 1, 0, 0);
        chk("prot_set", {31'd0, prot}, 32'd1);
        beat(0, 0, 0, 0, 32'h6004, 0, 0, 0, 0);
        beat(0, 1, 0, 0, 32'h6005, 0, 0, 0, 0);
        beat(1, 1, 0, 0, 32'h6006, 1, 0, 1, 0);
        gap(0, 1, 9'd1, 1);
        chk("prot_sticky", {31'd0, prot}, 32'd1);

        // Reset mid-TLP
        beat(1, 0, 0, 0, 32'h7001, 1, 0, 0, 0);
        beat(0, 0, 0, 0, 32'h7002, 1, 0, 0, 0);
        rst_n = 1'b0; valid = 1'b1; data = '0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_ctrl", {27'd0, wen, cl, pl, fl, cm}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; valid = 1'b0;
        chk("midrst_errs", {30'd0, ovf, prot}, 32'd0);
        beat(0, 0, 0, 0, 32'h7003, 0, 0, 0, 0);

        // Single digest-only beat TLP: commit 0, then realign
        beat(1, 1, 1, 0, 32'h8001, 1, 0, 1, 1);
        gap(1, 1, 9'd0, 0);
        gap(0, 0, 9'd0, 1);

        repeat (2) @(posedge clk);
        chk("sb_drain", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_rx_vc_data_wr_ctrl.md
Name: tl_rx_vc_data_wr_ctrl

Overview:
- Write-side controller placed directly upstream of the RX VC data buffer (one instance per P/NP/CPL buffer).
- Takes TLP payload beats from the RX TLP splitter and generates the buffer's write-enable, write-counter load (rollback) and write-pointer load (commit) controls, plus the digest-cycle flag.
- Performs free-space checking against the buffer's committed write pointer and read pointer. Discards nullified, errored and overflowing TLPs by rolling the buffer's write counter back to the last committed pointer.
- Reports committed beat counts to credit logic.

Parameters:
- DATA_FIFO_DEPTH, 256, buffer depth in beats (power of 2).
- DATA_PTR_SIZE, $clog2(DATA_FIFO_DEPTH)+1, pointer width including wrap bit.
- BUFFER_WIDTH, 256, beat width (8 DW).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_n_rst  in  1  reset, synchronous, active-low.
- i_tlp_valid  in  1  payload beat valid.
- o_ready  out  1  beat accepted when i_tlp_valid & o_ready.
- i_tlp_sop  in  1  first payload beat of a TLP.
- i_tlp_eop  in  1  last beat of the TLP.
- i_tlp_digest  in  1  qualified by eop: the last beat carries only the ECRC digest.
- i_tlp_discard  in  1  qualified by eop: TLP nullified, or LCRC/ECRC failed.
- i_tlp_data  in  BUFFER_WIDTH  beat payload.
- i_w_data_ptr  in  DATA_PTR_SIZE  committed write pointer from buffer.
- i_r_data_ptr  in  DATA_PTR_SIZE  read pointer from buffer.
- o_w_data_en  out  1  buffer write enable.
- o_w_tlp_data  out  BUFFER_WIDTH  buffer write data; equals i_tlp_data.
- o_w_data_cntr_ld  out  1  reload buffer write counter from committed pointer.
- o_w_data_ptr_ld  out  1  commit current TLP.
- o_digest_cycle_flag  out  1  commit excludes the final (digest) beat.
- o_commit  out  1  one-cycle pulse per committed TLP.
- o_commit_beats  out  DATA_PTR_SIZE  committed beat count; valid with o_commit.
- i_err_clr  in  1  clears sticky errors.
- o_overflow_err  out  1  sticky; a TLP was dropped for lack of space.
- o_protocol_err  out  1  sticky; sop received inside a TLP.

Behaviour:
- Reset (i_n_rst=0 at a clock edge):
  - State goes to IDLE; beat counter n=0; both sticky errors 0.
  - All outputs 0, except o_ready=0 during the reset cycle.
- Free space and acceptance:
  - free = DATA_FIFO_DEPTH - ((i_w_data_ptr - i_r_data_ptr) mod 2^DATA_PTR_SIZE).
  - A beat is space-OK iff n < free. This applies to digest beats as well, since they are physically written.
- Buffer controls are combinational from the accepted beat and the state (zero latency). State, n and the errors are registered.
- States:
  - IDLE:
    - Non-sop beats are consumed and dropped.
    - A sop beat that is space-OK: o_w_data_en=1 and n<=1, with one exception: if it is also eop with discard, the EOP rules apply. If sop without eop, go to RECV.
    - A sop beat that is not space-OK: overflow handling.
  - RECV:
    - Space-OK non-eop beat: o_w_data_en=1, n<=n+1.
    - sop beat: o_w_data_cntr_ld=1, no write, o_protocol_err<=1, go to DROP. The new TLP is also lost.
  - DROP:
    - Beats are consumed with no write.
    - On eop, go to IDLE with n<=0.
  - REALIGN:
    - Lasts one cycle; o_ready=0 and o_w_data_cntr_ld=1.
    - Then go to IDLE.
- EOP rules (IDLE with sop&eop, or RECV):
  - Discard has priority: o_w_data_en=0, o_w_data_cntr_ld=1, no commit, go to IDLE.
  - Otherwise, if space-OK: o_w_data_en=1, o_w_data_ptr_ld=1, o_digest_cycle_flag=i_tlp_digest.
    - Next cycle: o_commit=1 and o_commit_beats = n+1, or n if digest.
    - With digest, go to REALIGN: the buffer write counter is one ahead of the committed pointer and must be reloaded.
    - Without digest, go to IDLE.
- Overflow (any beat that is not space-OK while in IDLE/RECV): o_w_data_cntr_ld=1, no write, o_overflow_err<=1. Go to IDLE if the beat is eop, else DROP.
- Counter rules:
  - n resets to 0 on every transition to IDLE.
  - n saturates at DATA_FIFO_DEPTH; it cannot exceed that because free ≤ DEPTH.
- o_ready=1 in IDLE, RECV and DROP.
- Errors: cleared by i_err_clr; a new error event in the same cycle wins (error stays 1).
- Pointer arithmetic is modulo 2^DATA_PTR_SIZE. Full is when used == DEPTH (wrap bits differ, address bits equal); empty is when pointers are equal.
- Mid-TLP reset: the FSM returns to IDLE. The buffer is reset by the same reset, so no rollback is issued.

Test Plan:
- Empty buffer (ptrs 0/0), 4-beat TLP, no digest -> 4 writes; ptr_ld on beat 4 with flag 0; o_commit=1, o_commit_beats=4 next cycle.
- 3-beat TLP with digest -> 3 writes; ptr_ld with flag=1 on beat 3; o_commit_beats=2; next cycle REALIGN: o_ready=0, cntr_ld=1.
- 5-beat TLP with discard on eop -> 4 writes, beat 5 not written, cntr_ld=1, no o_commit, no error flags.
- w_ptr=254, r_ptr=0 (free=2), 4-beat TLP -> beats 1-2 written, beat 3 cntr_ld=1, o_overflow_err=1, beat 4 dropped; i_err_clr -> flag 0.
- Wrap: w_ptr=0x1FE, r_ptr=0x100 (used=254, free=2), 2-beat TLP -> both written, commit beats=2.
- sop mid-TLP after 2 beats -> cntr_ld=1, o_protocol_err=1, beats dropped until eop; reset asserted mid-TLP -> IDLE, all outputs 0.
